// File: rtl/button_debounce_sync_pkg.sv
// rtl/button_debounce_sync_pkg.sv - shared state encoding and defaults for the button debouncer
package button_debounce_sync_pkg;

  // Debounce window length: 10 ms at 50 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  // Debounce FSM states. The encoding is fixed so that the state stays readable in debug captures.
  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/button_debounce_sync_if.sv
// rtl/button_debounce_sync_if.sv - pin, clear and debounced-output bundle of the button debouncer
interface button_debounce_sync_if #(
  parameter int PCOUNT_W = 8
);

  logic                btn_raw;
  logic                press_count_clr;
  logic                btn_level;
  logic                btn_press;
  logic                btn_release;
  logic [PCOUNT_W-1:0] press_count;

  // master: the board pin and its consumers. slave: the debouncer itself.
  modport master (
    output btn_raw, press_count_clr,
    input  btn_level, btn_press, btn_release, press_count
  );

  modport slave (
    input  btn_raw, press_count_clr,
    output btn_level, btn_press, btn_release, press_count
  );

endinterface

// File: rtl/button_debounce_sync_sync_2ff.sv
// rtl/button_debounce_sync_sync_2ff.sv - 1-bit two-flop synchroniser with a configurable reset value
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // The raw pin enters meta with nothing in front of it; q is the first usable copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce_sync.sv
// rtl/button_debounce_sync.sv - debounces one push-button into a level, press/release strobes and a press counter
module button_debounce_sync
  import button_debounce_sync_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int PCOUNT_W        = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  button_debounce_sync_if.slave        bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                pin_sync;
  logic                s;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                press_d, release_d;
  logic                level_q, press_q, release_q;
  logic [PCOUNT_W-1:0] pcount_q;

  // The released pin level is the reset value, so leaving reset never looks like an edge.
  sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_raw),
    .q     (pin_sync)
  );

  // s = 1 means pressed regardless of board polarity.
  assign s = pin_sync ^ ACTIVE_LOW;

  // State, window counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= (state_d == S_PRESSED) || (state_d == S_RELEASE_WAIT);
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next state: a level change needs DEBOUNCE_CYCLES consecutive matching samples; any bounce restarts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      S_RELEASED: begin
        if (s) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      S_PRESS_WAIT: begin
        if (!s) begin
          state_d = S_RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PRESSED: begin
        if (!s) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      S_RELEASE_WAIT: begin
        if (s) begin
          state_d = S_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_RELEASED;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_RELEASED;
      end
    endcase
  end

  // Press counter follows the press strobe; a clear coinciding with a press keeps that press.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcount_q <= '0;
    end else if (bus.press_count_clr) begin
      pcount_q <= PCOUNT_W'(press_q);
    end else if (press_q) begin
      pcount_q <= pcount_q + PCOUNT_W'(1);
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.press_count = pcount_q;

endmodule
